// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing defaults, sync polarity constants and a span helper
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam logic POL_LOW = 1'b0;
  localparam logic POL_HIGH = 1'b1;
  function automatic int span(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_pix_tick_gen.sv
// vga_pix_tick_gen: divides clk by PIX_DIV while en is high; tick marks the last clk of each pixel
module vga_pix_tick_gen #(
  parameter int PIX_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(PIX_DIV - 1);
  logic [DW-1:0] div;
  assign tick = en && div == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div <= '0;
    else if (en) div <= tick ? '0 : div + 1'b1;
endmodule

// File: rtl/vga_sync_timing.sv
// vga_sync_timing: VGA horizontal/vertical counters with registered syncs, video_on and strobes.
// Outputs decode next-state counters so every output is coherent with pix_x/pix_y.
module vga_sync_timing import vga_timing_pkg::*; #(
  parameter int PIX_DIV = 4,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter logic HS_POL = POL_LOW,
  parameter logic VS_POL = POL_LOW,
  parameter int CNT_W = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic hsync,
  output logic vsync,
  output logic video_on,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic pix_tick,
  output logic line_start,
  output logic frame_start
);
  localparam int H_TOTAL = span(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  if (PIX_DIV < 1) begin : g_bad_div
    $error("vga_sync_timing: PIX_DIV must be >= 1");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("vga_sync_timing: porch and sync widths must be >= 1");
  end
  if (2 ** CNT_W < H_TOTAL || 2 ** CNT_W < V_TOTAL) begin : g_bad_width
    $error("vga_sync_timing: CNT_W too small for the frame totals");
  end
  logic tick, h_wrap;
  logic [CNT_W-1:0] x_nxt, y_nxt;
  vga_pix_tick_gen #(.PIX_DIV(PIX_DIV)) u_tick (.clk, .rst_n, .en, .tick);
  always_comb begin
    h_wrap = tick && pix_x == H_LAST;
    x_nxt = h_wrap ? '0 : pix_x + CNT_W'(tick);
    y_nxt = !h_wrap ? pix_y : pix_y == V_LAST ? '0 : pix_y + 1'b1;
  end
  // Reset parks on the last blanking position so the first tick lands on (0, 0)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pix_x <= H_LAST;
      pix_y <= V_LAST;
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      video_on <= 1'b0;
      pix_tick <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_x <= x_nxt;
      pix_y <= y_nxt;
      hsync <= (x_nxt >= HS_BEG && x_nxt <= HS_END) ? HS_POL : ~HS_POL;
      vsync <= (y_nxt >= VS_BEG && y_nxt <= VS_END) ? VS_POL : ~VS_POL;
      video_on <= x_nxt < H_VIS && y_nxt < V_VIS;
      pix_tick <= tick;
      line_start <= tick && x_nxt == '0;
      frame_start <= tick && x_nxt == '0 && y_nxt == '0;
    end
endmodule

// File: tb/tb_vga_sync_timing.sv
// tb_vga_sync_timing: default 640x480 instance plus two reduced-frame instances (PIX_DIV 4 and
// PIX_DIV 1 with inverted polarity), a per-cycle reference scoreboard and directed corner sequences.
module tb_vga_sync_timing;
  typedef struct { int pd, ha, hfp, hs, hbp, va, vfp, vs, vbp; logic hp, vp; } cfg_t;
  typedef struct { int id; logic [25:0] v; } sb_t;
  typedef struct { int c, x, y; logic h, v, o, t, l, f; } vec_t;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n [3];
  logic en [3];
  logic hs [3], vs [3], vo [3], tk [3], ls [3], fs [3];
  logic [9:0] px [3], py [3];
  cfg_t cfg [3];
  sb_t sbq [$];
  sb_t se;
  vec_t tbl [$];
  int mpos [3], mdiv [3];
  logic mtk [3];
  int nchk = 0, npass = 0;
  vga_sync_timing d0 (.clk(clk), .rst_n(rst_n[0]), .en(en[0]), .hsync(hs[0]), .vsync(vs[0]),
    .video_on(vo[0]), .pix_x(px[0]), .pix_y(py[0]), .pix_tick(tk[0]), .line_start(ls[0]),
    .frame_start(fs[0]));
  vga_sync_timing #(.PIX_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4),
    .V_FP(1), .V_SYNC(2), .V_BP(1)) d1 (.clk(clk), .rst_n(rst_n[1]), .en(en[1]), .hsync(hs[1]),
    .vsync(vs[1]), .video_on(vo[1]), .pix_x(px[1]), .pix_y(py[1]), .pix_tick(tk[1]),
    .line_start(ls[1]), .frame_start(fs[1]));
  vga_sync_timing #(.PIX_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4),
    .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)) d2 (.clk(clk),
    .rst_n(rst_n[2]), .en(en[2]), .hsync(hs[2]), .vsync(vs[2]), .video_on(vo[2]),
    .pix_x(px[2]), .pix_y(py[2]), .pix_tick(tk[2]), .line_start(ls[2]), .frame_start(fs[2]));
  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    nchk++;
    if (a === e) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask
  function automatic int ftot(cfg_t c);
    return (c.ha + c.hfp + c.hs + c.hbp) * (c.va + c.vfp + c.vs + c.vbp);
  endfunction
  // Reference decode from a linear in-frame position: x = pos mod H_TOTAL, y = pos div H_TOTAL
  function automatic logic [25:0] expv(cfg_t c, int pos, logic t);
    int ht, x, y;
    logic ha, va;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    x = pos % ht;
    y = pos / ht;
    ha = x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hs;
    va = y >= c.va + c.vfp && y < c.va + c.vfp + c.vs;
    return {ha ? c.hp : ~c.hp, va ? c.vp : ~c.vp, logic'(x < c.ha && y < c.va), t,
            logic'(t && x == 0), logic'(t && pos == 0), 10'(x), 10'(y)};
  endfunction
  function automatic logic [25:0] actv(int i);
    return {hs[i], vs[i], vo[i], tk[i], ls[i], fs[i], px[i], py[i]};
  endfunction
  always @(posedge clk)
    for (int i = 0; i < 3; i++) begin
      if (!rst_n[i]) begin
        mpos[i] = ftot(cfg[i]) - 1;
        mdiv[i] = 0;
        mtk[i] = 0;
      end else if (!en[i]) mtk[i] = 0;
      else if (mdiv[i] == cfg[i].pd - 1) begin
        mdiv[i] = 0;
        mpos[i] = (mpos[i] + 1) % ftot(cfg[i]);
        mtk[i] = 1;
      end else begin
        mdiv[i] = mdiv[i] + 1;
        mtk[i] = 0;
      end
      sbq.push_back('{i, expv(cfg[i], mpos[i], mtk[i])});
    end
  always @(negedge clk)
    while (sbq.size() > 0) begin
      se = sbq.pop_front();
      chk($sformatf("scoreboard d%0d", se.id), 32'(actv(se.id)), 32'(se.v));
    end
  task automatic measure(int i, int lim, output int per, output int hsa, output int vsa,
                         output int vot, output int tkc);
    int n;
    per = 0; hsa = 0; vsa = 0; vot = 0; tkc = 0; n = 0;
    while (fs[i] !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) begin
      chk($sformatf("frame_start wait d%0d", i), 0, 1);
      return;
    end
    do begin
      hsa += int'(hs[i] === cfg[i].hp);
      vsa += int'(vs[i] === cfg[i].vp);
      vot += int'(tk[i] && vo[i]);
      tkc += int'(tk[i]);
      per++;
      @(negedge clk);
    end while (fs[i] !== 1'b1 && per < lim);
  endtask
  initial begin
    int cur, c, t, h, per, hsa, vsa, vot, tkc;
    cfg[0] = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg[1] = '{4, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0};
    cfg[2] = '{1, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 0;
      en[i] = 1;
    end
    //         clk   x    y   hs vs vo tk ls fs
    tbl.push_back('{0, 799, 524, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{3, 799, 524, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{4, 0, 0, 1, 1, 1, 1, 1, 1});
    tbl.push_back('{5, 0, 0, 1, 1, 1, 0, 0, 0});
    tbl.push_back('{2560, 639, 0, 1, 1, 1, 1, 0, 0});
    tbl.push_back('{2564, 640, 0, 1, 1, 0, 1, 0, 0});
    tbl.push_back('{2566, 640, 0, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{2628, 656, 0, 0, 1, 0, 1, 0, 0});
    tbl.push_back('{3008, 751, 0, 0, 1, 0, 1, 0, 0});
    tbl.push_back('{3012, 752, 0, 1, 1, 0, 1, 0, 0});
    tbl.push_back('{3200, 799, 0, 1, 1, 0, 1, 0, 0});
    tbl.push_back('{3204, 0, 1, 1, 1, 1, 1, 1, 0});
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst_n[i] = 1;
    cur = 0;
    foreach (tbl[k]) begin
      repeat (tbl[k].c - cur) @(negedge clk);
      cur = tbl[k].c;
      chk($sformatf("vector clk%0d", tbl[k].c), 32'(actv(0)),
          32'({tbl[k].h, tbl[k].v, tbl[k].o, tbl[k].t, tbl[k].l, tbl[k].f,
               10'(tbl[k].x), 10'(tbl[k].y)}));
    end
    // Freeze d0 mid-hsync at x=700 for 37 clks, then confirm the line still closes correctly
    repeat (6004 - cur) @(negedge clk);
    #1 en[0] = 0;
    repeat (37) @(negedge clk);
    chk("frozen d0", 32'(actv(0)), 32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd700, 10'd1}));
    #1 en[0] = 1;
    c = 0; t = 0;
    while (c < 5000) begin
      @(negedge clk);
      c++;
      if (tk[0]) t++;
      if (ls[0]) break;
    end
    chk("ticks to line end after resume", 32'(t), 32'd100);
    c = 0; t = 0; h = 0;
    while (c < 5000) begin
      @(negedge clk);
      c++;
      if (tk[0]) begin
        t++;
        if (hs[0] === 1'b0) h++;
      end
      if (ls[0]) break;
    end
    chk("line ticks after resume", 32'(t), 32'd800);
    chk("hsync ticks after resume", 32'(h), 32'd96);
    measure(1, 1000, per, hsa, vsa, vot, tkc);
    chk("d1 frame period", 32'(per), 32'd480);
    chk("d1 hsync clks", 32'(hsa), 32'd96);
    chk("d1 vsync clks", 32'(vsa), 32'd120);
    chk("d1 video ticks", 32'(vot), 32'd32);
    chk("d1 tick clks", 32'(tkc), 32'd120);
    measure(2, 300, per, hsa, vsa, vot, tkc);
    chk("d2 frame period", 32'(per), 32'd120);
    chk("d2 hsync clks", 32'(hsa), 32'd24);
    chk("d2 vsync clks", 32'(vsa), 32'd30);
    chk("d2 video ticks", 32'(vot), 32'd32);
    chk("d2 tick clks", 32'(tkc), 32'd120);
    // Reset d1 while vsync is active; the pulse must drop immediately
    c = 0;
    while (py[1] !== 10'd6 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk("d1 reach vsync line", 32'(py[1]), 32'd6);
    chk("d1 vsync active before reset", 32'(vs[1]), 32'd0);
    #1 rst_n[1] = 0;
    #1;
    chk("d1 async reset", 32'(actv(1)), 32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd14, 10'd7}));
    repeat (2) @(negedge clk);
    #1 rst_n[1] = 1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (fs[1] !== 1'b1 && c < 20);
    chk("d1 frame_start after reset", 32'(c), 32'd4);
    chk("d1 origin after reset", 32'({px[1], py[1], vo[1]}), 32'({10'd0, 10'd0, 1'b1}));
    @(negedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/vga_sync_timing.md
Name: vga_sync_timing

Overview:
- Parametrised VGA timing generator; successor to the standalone combinational vertical-sync decoder.
- Owns the pixel-enable divider and the horizontal and vertical counters.
- Generates hsync and vsync with programmable polarity, plus video_on, pixel coordinates and line/frame strobes.
- Sits between the board clock and the pixel/framebuffer logic; every display-side block consumes its outputs.

Parameters:
- PIX_DIV, 4, clk cycles per pixel (1 = one pixel every clk; 4 gives 25 MHz from 100 MHz).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width in pixels.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch.
- HS_POL, 0, hsync active level (0 = active-low).
- VS_POL, 0, vsync active level.
- CNT_W, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; low freezes timing.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- video_on  out  1  high while (pix_x, pix_y) is inside the active area.
- pix_x  out  CNT_W  current horizontal count.
- pix_y  out  CNT_W  current vertical count.
- pix_tick  out  1  one-clk pulse when counters advance.
- line_start  out  1  one-clk pulse when pix_x becomes 0.
- frame_start  out  1  one-clk pulse when (pix_x, pix_y) becomes (0, 0).

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (async assert, sync release):
  - div = 0, pix_x = H_TOTAL-1, pix_y = V_TOTAL-1.
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - video_on = 0; pix_tick, line_start, frame_start = 0.
  - Reset values are a coherent blanking position, so the first tick wraps to (0, 0) and fires frame_start.
- Divider:
  - div counts 0..PIX_DIV-1 while en = 1.
  - Tick condition: en = 1 and div = PIX_DIV-1; div then wraps to 0.
  - PIX_DIV = 1: tick on every en-high clk.
- Counters update on tick only:
  - pix_x = pix_x+1, wrapping to 0 after H_TOTAL-1.
  - On that wrap, pix_y = pix_y+1, wrapping to 0 after V_TOTAL-1.
- All outputs are registered and decoded from next-state counter values, so hsync, vsync, video_on and the strobes are coherent with pix_x/pix_y in the same cycle (zero relative skew).
- hsync is active (= HS_POL) iff H_ACTIVE+H_FP <= pix_x <= H_ACTIVE+H_FP+H_SYNC-1 (656..751).
- vsync is active (= VS_POL) iff V_ACTIVE+V_FP <= pix_y <= V_ACTIVE+V_FP+V_SYNC-1 (490..491). It changes only at line boundaries.
- video_on = (pix_x < H_ACTIVE) && (pix_y < V_ACTIVE).
- Strobe timing:
  - pix_tick is high in the clk after the counters have advanced.
  - line_start and frame_start are high in that same clk when the new pix_x = 0, or new (pix_x, pix_y) = (0, 0).
  - All three are one clk wide regardless of PIX_DIV.
- en = 0:
  - div, counters, hsync, vsync, video_on hold.
  - Strobes are 0.
  - On resume, timing continues from the held div value; no skipped or duplicated pixel.
- Reset mid-frame: immediately returns to reset values, outputs included; no partial sync pulse is stretched.
- Elaboration-time checks (simulation $error), each parameter set must satisfy:
  - PIX_DIV >= 1.
  - Every porch/sync value >= 1.
  - 2^CNT_W >= max(H_TOTAL, V_TOTAL).

Decomposition:
- Package vga_timing_pkg:
  - 640x480@60 default constants (H_/V_ ACTIVE/FP/SYNC/BP).
  - Polarity constants POL_LOW = 0, POL_HIGH = 1.
  - Function for total/width calculation.
- Sub-module vga_pix_tick_gen: PIX_DIV divider with en, producing the internal tick. The timing counters and decoders remain in vga_sync_timing.

Test Plan:
- Reset: hold rst_n = 0, then release -> pix_x = 799, pix_y = 524, hsync = vsync = 1, video_on = 0. First frame_start occurs exactly PIX_DIV = 4 clks after release, with pix_x = pix_y = 0 and video_on = 1.
- Default frame timing: run 2 frames -> frame_start period is 800*525*4 = 1,680,000 clks. hsync is low for pix_x 656..751 (384 clks per line). vsync is low for exactly 2 lines (pix_y 490..491, 6,400 clks).
- Active area: count video_on-high pix_ticks per frame -> 307,200. video_on is low at pix_x = 640 and at pix_y = 480.
- Polarity/divider: HS_POL = VS_POL = 1, PIX_DIV = 1 -> sync pulses are inverted (high during 656..751 and 490..491). pix_tick is high every clk. Frame period = 420,000 clks.
- Enable: deassert en for 37 clks at pix_x = 700 -> all outputs frozen, strobes 0. After re-enable, the line still totals 800 ticks and hsync width is still 96 ticks.
- Mid-frame reset: assert rst_n = 0 during vsync (pix_y = 491) -> vsync immediately = 1 and counters = (799, 524). After release, the next frame_start follows 4 clks later.
